wb_regfile_commit: RTL and testbench

WB_REGFILE_COMMIT -- requirements
Module: wb_regfile_commit

---
 rtl/wb_regfile_commit_if.sv | 46 ++++
 rtl/wb_regfile_commit.sv | 121 ++++++++++++
 tb/tb_wb_regfile_commit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_commit_if.sv
// WB-stage bus for wb_regfile_commit: writeback inputs, read ports, forwarding bus and commit record.
// instret_o is present only when WB_INSTRET_EN is defined.
interface wb_regfile_commit_if;
    logic [31:0] pc_wb_i;
    logic        instr_valid_wb_i;
    logic        rf_we_wb_i;
    logic [4:0]  wr_wb_i;
    logic [31:0] wd_wb_i;
    logic [31:0] dram_data_wb_i;
    logic [1:0]  wd_sel_wb_i;
    logic [4:0]  rR1_i;
    logic [4:0]  rR2_i;
    logic [31:0] rD1_o;
    logic [31:0] rD2_o;
    logic        wb_fwd_valid_o;
    logic [4:0]  wb_fwd_rd_o;
    logic [31:0] wb_fwd_data_o;
    logic        commit_valid_o;
    logic [31:0] commit_pc_o;
    logic [4:0]  commit_rd_o;
    logic        commit_we_o;
    logic [31:0] commit_data_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
`endif

    modport master (
        output pc_wb_i, instr_valid_wb_i, rf_we_wb_i, wr_wb_i, wd_wb_i, dram_data_wb_i,
               wd_sel_wb_i, rR1_i, rR2_i,
`ifdef WB_INSTRET_EN
        input  instret_o,
`endif
        input  rD1_o, rD2_o, wb_fwd_valid_o, wb_fwd_rd_o, wb_fwd_data_o,
               commit_valid_o, commit_pc_o, commit_rd_o, commit_we_o, commit_data_o
    );

    modport slave (
        input  pc_wb_i, instr_valid_wb_i, rf_we_wb_i, wr_wb_i, wd_wb_i, dram_data_wb_i,
               wd_sel_wb_i, rR1_i, rR2_i,
`ifdef WB_INSTRET_EN
        output instret_o,
`endif
        output rD1_o, rD2_o, wb_fwd_valid_o, wb_fwd_rd_o, wb_fwd_data_o,
               commit_valid_o, commit_pc_o, commit_rd_o, commit_we_o, commit_data_o
    );
endinterface

// File: rtl/wb_regfile_commit.sv
// Writeback stage: write-data mux, 32x32 register file with same-cycle read bypass, forwarding bus
// and registered retire record. Define WB_INSTRET_EN to add the 64-bit retired-instruction counter.
module wb_regfile_commit #(
    parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst,
    wb_regfile_commit_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    logic [XLEN-1:0] wdata_c;
    logic            wen_c;
    logic [XLEN-1:0] rd1_c;
    logic [XLEN-1:0] rd2_c;

    logic            commit_valid_q, commit_valid_d;
    logic [XLEN-1:0] commit_pc_q,    commit_pc_d;
    logic [AW-1:0]   commit_rd_q,    commit_rd_d;
    logic            commit_we_q,    commit_we_d;
    logic [XLEN-1:0] commit_data_q,  commit_data_d;
`ifdef WB_INSTRET_EN
    logic [63:0]     instret_q,      instret_d;
`endif

    // Final write data and effective write enable; x0 is never a write target.
    always_comb begin
        unique case (bus.wd_sel_wb_i)
            2'b01:   wdata_c = bus.dram_data_wb_i;
            2'b10:   wdata_c = bus.pc_wb_i + XLEN'(4);
            default: wdata_c = bus.wd_wb_i;
        endcase
        wen_c = bus.instr_valid_wb_i & bus.rf_we_wb_i & (bus.wr_wb_i != AW'(0));
    end

    always_comb begin
        rf_d = rf_q;
        if (wen_c) begin
            rf_d[bus.wr_wb_i] = wdata_c;
        end
        rf_d[0] = '0;
    end

    // Read ports see the in-flight WB write with zero latency.
    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        if (bus.rR1_i != AW'(0)) begin
            rd1_c = (wen_c && (bus.rR1_i == bus.wr_wb_i)) ? wdata_c : rf_q[bus.rR1_i];
        end
        if (bus.rR2_i != AW'(0)) begin
            rd2_c = (wen_c && (bus.rR2_i == bus.wr_wb_i)) ? wdata_c : rf_q[bus.rR2_i];
        end
    end

    // Retire record: valid pulses per instruction, payload holds between retirements.
    always_comb begin
        commit_valid_d = bus.instr_valid_wb_i;
        commit_pc_d    = commit_pc_q;
        commit_rd_d    = commit_rd_q;
        commit_we_d    = commit_we_q;
        commit_data_d  = commit_data_q;
        if (bus.instr_valid_wb_i) begin
            commit_pc_d   = bus.pc_wb_i;
            commit_rd_d   = bus.wr_wb_i;
            commit_we_d   = wen_c;
            commit_data_d = wdata_c;
        end
    end

`ifdef WB_INSTRET_EN
    always_comb begin
        instret_d = instret_q + 64'(bus.instr_valid_wb_i);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q[0] <= '0;
            for (int i = 1; i < int'(NREG); i++) begin
                rf_q[i] <= REG_RESET_VAL;
            end
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_rd_q    <= '0;
            commit_we_q    <= 1'b0;
            commit_data_q  <= '0;
`ifdef WB_INSTRET_EN
            instret_q      <= '0;
`endif
        end else begin
            rf_q           <= rf_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_rd_q    <= commit_rd_d;
            commit_we_q    <= commit_we_d;
            commit_data_q  <= commit_data_d;
`ifdef WB_INSTRET_EN
            instret_q      <= instret_d;
`endif
        end
    end

    assign bus.rD1_o          = rd1_c;
    assign bus.rD2_o          = rd2_c;
    assign bus.wb_fwd_valid_o = wen_c;
    assign bus.wb_fwd_rd_o    = bus.wr_wb_i;
    assign bus.wb_fwd_data_o  = wdata_c;
    assign bus.commit_valid_o = commit_valid_q;
    assign bus.commit_pc_o    = commit_pc_q;
    assign bus.commit_rd_o    = commit_rd_q;
    assign bus.commit_we_o    = commit_we_q;
    assign bus.commit_data_o  = commit_data_q;
`ifdef WB_INSTRET_EN
    assign bus.instret_o      = instret_q;
`endif
endmodule

// File: tb/tb_wb_regfile_commit.sv
// Self-checking bench for wb_regfile_commit: directed cases plus randomized traffic against an
// array/record reference model of the writeback stage.
module tb_wb_regfile_commit;
    localparam logic [31:0] RST_VAL = 32'hA5A5_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_regfile_commit_if bus ();
    wb_regfile_commit #(.REG_RESET_VAL(RST_VAL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_rf [32];
    logic        m_cv, m_cwe;
    logic [31:0] m_cpc, m_cdata;
    logic [4:0]  m_crd;
    logic [63:0] m_instret;

    // Currently applied WB inputs.
    logic        t_valid, t_we;
    logic [4:0]  t_rd;
    logic [1:0]  t_sel;
    logic [31:0] t_wd, t_dram, t_pc;

    function automatic logic [31:0] exp_data();
        if (t_sel == 2'b01) return t_dram;
        if (t_sel == 2'b10) return t_pc + 32'd4;
        return t_wd;
    endfunction

    function automatic logic exp_wen();
        return t_valid && t_we && (t_rd != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (exp_wen() && idx == t_rd) return exp_data();
        return m_rf[idx];
    endfunction

    task automatic model_reset();
        m_rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) m_rf[i] = RST_VAL;
        m_cv = 1'b0; m_cwe = 1'b0; m_cpc = 32'd0; m_cdata = 32'd0; m_crd = 5'd0;
        m_instret = 64'd0;
    endtask

    task automatic drive(input logic valid, input logic we, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] wd, input logic [31:0] dram, input logic [31:0] pc,
                         input logic [4:0] r1, input logic [4:0] r2);
        t_valid = valid; t_we = we; t_rd = rd; t_sel = sel; t_wd = wd; t_dram = dram; t_pc = pc;
        bus.instr_valid_wb_i = valid; bus.rf_we_wb_i = we; bus.wr_wb_i = rd; bus.wd_sel_wb_i = sel;
        bus.wd_wb_i = wd; bus.dram_data_wb_i = dram; bus.pc_wb_i = pc;
        bus.rR1_i = r1; bus.rR2_i = r2;
        #1;
    endtask

    // Advance one clock edge and apply the architectural effect of the current WB inputs.
    task automatic tick();
        logic [31:0] d;
        logic        w;
        d = exp_data();
        w = exp_wen();
        @(posedge clk);
        if (!rst) begin
            if (w) m_rf[t_rd] = d;
            m_cv = t_valid;
            if (t_valid) begin
                m_cpc = t_pc; m_crd = t_rd; m_cwe = w; m_cdata = d;
                m_instret = m_instret + 64'd1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, r1, r2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(5'd0, 5'd0);
        model_reset();
        #2;
        if (bus.commit_valid_o !== 1'b0 || bus.commit_pc_o !== 32'd0 || bus.commit_rd_o !== 5'd0 ||
            bus.commit_we_o !== 1'b0 || bus.commit_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_commit: got v=%b pc=%h rd=%0d we=%b d=%h required all zero",
                     bus.commit_valid_o, bus.commit_pc_o, bus.commit_rd_o, bus.commit_we_o, bus.commit_data_o);
        end
        n_checks++;
`ifdef WB_INSTRET_EN
        if (bus.instret_o !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %h required 0", bus.instret_o); end
        n_checks++;
`endif
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            if (bus.rD1_o !== exp_read(5'(i)) || bus.rD2_o !== exp_read(5'(31 - i))) begin
                n_fail++;
                $display("FAIL reset_regs x%0d/x%0d: got %h/%h required %h/%h", i, 31 - i,
                         bus.rD1_o, bus.rD2_o, exp_read(5'(i)), exp_read(5'(31 - i)));
            end
            n_checks++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        // Plain ALU write to x5 with same-cycle bypass.
        drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 32'h0000_0100, 5'd5, 5'd0);
        if (bus.rD1_o !== 32'h1234 || bus.rD2_o !== 32'd0) begin
            n_fail++; $display("FAIL bypass_x5: got %h/%h required 00001234/00000000", bus.rD1_o, bus.rD2_o);
        end
        n_checks++;
        if (bus.wb_fwd_valid_o !== 1'b1 || bus.wb_fwd_rd_o !== 5'd5 || bus.wb_fwd_data_o !== 32'h1234) begin
            n_fail++; $display("FAIL fwd_x5: got %b/%0d/%h required 1/5/00001234",
                               bus.wb_fwd_valid_o, bus.wb_fwd_rd_o, bus.wb_fwd_data_o);
        end
        n_checks++;
        tick();
        if (bus.commit_valid_o !== 1'b1 || bus.commit_pc_o !== 32'h100 || bus.commit_rd_o !== 5'd5 ||
            bus.commit_we_o !== 1'b1 || bus.commit_data_o !== 32'h1234) begin
            n_fail++; $display("FAIL commit_x5: got v=%b pc=%h rd=%0d we=%b d=%h", bus.commit_valid_o,
                               bus.commit_pc_o, bus.commit_rd_o, bus.commit_we_o, bus.commit_data_o);
        end
        n_checks++;
        // DRAM load into x7, then link write with PC wrap into x9.
        drive(1'b1, 1'b1, 5'd7, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_0104, 5'd5, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd9, 2'b10, 32'h2222_2222, 32'h3333_3333, 32'hFFFF_FFFC, 5'd0, 5'd0);
        if (bus.wb_fwd_data_o !== 32'd0) begin
            n_fail++; $display("FAIL pc_wrap_fwd: got %h required 00000000", bus.wb_fwd_data_o);
        end
        n_checks++;
        tick();
        idle(5'd7, 5'd9);
        if (bus.rD1_o !== 32'hDEAD_BEEF || bus.rD2_o !== 32'd0) begin
            n_fail++; $display("FAIL x7_x9: got %h/%h required deadbeef/00000000", bus.rD1_o, bus.rD2_o);
        end
        n_checks++;
        if (bus.rD1_o !== exp_read(5'd7)) begin n_fail++; $display("FAIL x7_model: got %h required %h", bus.rD1_o, exp_read(5'd7)); end
        n_checks++;
        // Write aimed at x0 is dropped but still retires.
        drive(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_FFFF, 32'h0, 32'h0000_0200, 5'd0, 5'd0);
        if (bus.rD1_o !== 32'd0 || bus.wb_fwd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL x0_write: got rd=%h fwd=%b required 0/0", bus.rD1_o, bus.wb_fwd_valid_o);
        end
        n_checks++;
        tick();
        if (bus.commit_valid_o !== 1'b1 || bus.commit_we_o !== 1'b0 || bus.commit_rd_o !== 5'd0) begin
            n_fail++; $display("FAIL x0_commit: got v=%b we=%b rd=%0d required 1/0/0",
                               bus.commit_valid_o, bus.commit_we_o, bus.commit_rd_o);
        end
        n_checks++;
        // Bubble with write enable set: no write, no forward, no commit, no count.
        drive(1'b0, 1'b1, 5'd3, 2'b00, 32'h7777_7777, 32'h0, 32'h0000_0300, 5'd3, 5'd0);
        if (bus.wb_fwd_valid_o !== 1'b0 || bus.rD1_o !== RST_VAL) begin
            n_fail++; $display("FAIL bubble_comb: got fwd=%b rd=%h required 0/%h", bus.wb_fwd_valid_o, bus.rD1_o, RST_VAL);
        end
        n_checks++;
        tick();
        idle(5'd3, 5'd0);
        if (bus.commit_valid_o !== 1'b0 || bus.commit_pc_o !== 32'h200 || bus.rD1_o !== RST_VAL) begin
            n_fail++; $display("FAIL bubble_seq: got v=%b pc=%h x3=%h required 0/00000200/%h",
                               bus.commit_valid_o, bus.commit_pc_o, bus.rD1_o, RST_VAL);
        end
        n_checks++;
`ifdef WB_INSTRET_EN
        if (bus.instret_o !== m_instret) begin n_fail++; $display("FAIL bubble_instret: got %0d required %0d", bus.instret_o, m_instret); end
        n_checks++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) begin
            v = $urandom;
            drive(1'b1, 1'b1, 5'd10, 2'b00, v, 32'h0, 32'h1000 + 32'(4 * k), 5'd10, 5'd10);
            if (bus.rD1_o !== v || bus.rD2_o !== v) begin
                n_fail++; $display("FAIL b2b_bypass %0d: got %h/%h required %h", k, bus.rD1_o, bus.rD2_o, v);
            end
            n_checks++;
            tick();
            if (bus.commit_valid_o !== 1'b1 || bus.commit_data_o !== v) begin
                n_fail++; $display("FAIL b2b_commit %0d: got v=%b d=%h required 1/%h", k, bus.commit_valid_o, bus.commit_data_o, v);
            end
            n_checks++;
        end
        idle(5'd10, 5'd0);
        if (bus.rD1_o !== m_rf[10]) begin n_fail++; $display("FAIL b2b_final: got %h required %h", bus.rD1_o, m_rf[10]); end
        n_checks++;
    endtask

    task automatic test_random(input int cycles);
        logic [4:0] rd, r1, r2;
        for (int c = 0; c < cycles; c++) begin
            rd = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), rd, 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, r1, r2);
            if (bus.rD1_o !== exp_read(r1) || bus.rD2_o !== exp_read(r2)) begin
                n_fail++; $display("FAIL rand_read c%0d: got %h/%h required %h/%h", c, bus.rD1_o, bus.rD2_o, exp_read(r1), exp_read(r2));
            end
            n_checks++;
            if (bus.wb_fwd_valid_o !== exp_wen() || bus.wb_fwd_rd_o !== rd || bus.wb_fwd_data_o !== exp_data()) begin
                n_fail++; $display("FAIL rand_fwd c%0d: got %b/%0d/%h required %b/%0d/%h", c, bus.wb_fwd_valid_o,
                                   bus.wb_fwd_rd_o, bus.wb_fwd_data_o, exp_wen(), rd, exp_data());
            end
            n_checks++;
            tick();
            if (bus.commit_valid_o !== m_cv || bus.commit_pc_o !== m_cpc || bus.commit_rd_o !== m_crd ||
                bus.commit_we_o !== m_cwe || bus.commit_data_o !== m_cdata) begin
                n_fail++; $display("FAIL rand_commit c%0d: got %b/%h/%0d/%b/%h required %b/%h/%0d/%b/%h", c,
                                   bus.commit_valid_o, bus.commit_pc_o, bus.commit_rd_o, bus.commit_we_o, bus.commit_data_o,
                                   m_cv, m_cpc, m_crd, m_cwe, m_cdata);
            end
            n_checks++;
`ifdef WB_INSTRET_EN
            if (bus.instret_o !== m_instret) begin n_fail++; $display("FAIL rand_instret c%0d: got %0d required %0d", c, bus.instret_o, m_instret); end
            n_checks++;
`endif
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b1, 5'd12, 2'b00, 32'hCAFE_F00D, 32'h0, 32'h0000_4000, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd13, 2'b00, 32'h1357_9BDF, 32'h0, 32'h0000_4004, 5'd12, 5'd13);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        if (bus.commit_valid_o !== 1'b0 || bus.commit_pc_o !== 32'd0 || bus.commit_rd_o !== 5'd0 ||
            bus.commit_we_o !== 1'b0 || bus.commit_data_o !== 32'd0) begin
            n_fail++; $display("FAIL midrst_commit: got v=%b pc=%h rd=%0d we=%b d=%h required all zero",
                               bus.commit_valid_o, bus.commit_pc_o, bus.commit_rd_o, bus.commit_we_o, bus.commit_data_o);
        end
        n_checks++;
`ifdef WB_INSTRET_EN
        if (bus.instret_o !== 64'd0) begin n_fail++; $display("FAIL midrst_instret: got %h required 0", bus.instret_o); end
        n_checks++;
`endif
        // Held reset through an edge with a valid write pending.
        tick();
        idle(5'd12, 5'd13);
        if (bus.rD1_o !== RST_VAL || bus.rD2_o !== RST_VAL || bus.commit_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_hold: got %h/%h v=%b required %h/%h v=0", bus.rD1_o, bus.rD2_o,
                               bus.commit_valid_o, RST_VAL, RST_VAL);
        end
        n_checks++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 5'd12, 2'b00, 32'h0BAD_C0DE, 32'h0, 32'h0000_5000, 5'd0, 5'd0);
        tick();
        idle(5'd12, 5'd0);
        if (bus.rD1_o !== 32'h0BAD_C0DE || bus.commit_valid_o !== 1'b1 || bus.commit_pc_o !== 32'h5000) begin
            n_fail++; $display("FAIL midrst_resume: got %h v=%b pc=%h required 0badc0de/1/00005000",
                               bus.rD1_o, bus.commit_valid_o, bus.commit_pc_o);
        end
        n_checks++;
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret_wrap();
        @(negedge clk);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        idle(5'd0, 5'd0);
        if (bus.instret_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL instret_forced: got %h required ffffffffffffffff", bus.instret_o);
        end
        n_checks++;
        drive(1'b1, 1'b0, 5'd1, 2'b00, 32'h0, 32'h0, 32'h0000_6000, 5'd0, 5'd0);
        tick();
        if (bus.instret_o !== 64'd0) begin n_fail++; $display("FAIL instret_wrap: got %h required 0", bus.instret_o); end
        n_checks++;
        m_instret = bus.commit_valid_o ? 64'd0 : 64'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random(400);
        test_reset_midstream();
        test_random(100);
`ifdef WB_INSTRET_EN
        test_instret_wrap();
        test_random(50);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
